// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        kill,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_b;       // multiplicand (mul) or divisor (div) magnitude
   logic [31:0] r_hi;      // product high half (mul) or partial remainder (div)
   logic [31:0] r_lo;      // multiplier/product low half (mul) or dividend/quotient (div)
   logic        r_neg;     // final negation required in FIX
   logic [31:0] r_result;

   logic        w_a_signed;
   logic        w_b_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_neg;
   logic [32:0] w_sum;
   logic [32:0] w_shift;
   logic [33:0] w_diff;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;
   logic [63:0] w_prod;
   logic [31:0] w_rem;
   logic [31:0] w_quo;
   logic [31:0] w_fix;

   // Operand sign decode and magnitudes at acceptance time
   always_comb begin
      w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      w_a_neg    = w_a_signed & src_a[31];
      w_b_neg    = w_b_signed & src_b[31];
      w_a_mag    = w_a_neg ? (32'd0 - src_a) : src_a;
      w_b_mag    = w_b_neg ? (32'd0 - src_b) : src_b;
      // Divide-by-zero keeps the all-ones quotient unnegated; the remainder
      // magnitude is |a| and negating it for a negative dividend restores src_a.
      case (op)
         3'b001:  w_neg = w_a_neg ^ w_b_neg;
         3'b010:  w_neg = w_a_neg;
         3'b100:  w_neg = (w_a_neg ^ w_b_neg) & (src_b != 32'd0);
         3'b110:  w_neg = w_a_neg;
         default: w_neg = 1'b0;
      endcase
   end

   // One shift-add or restoring-divide step per CALC cycle
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
      w_shift = {r_hi, r_lo[31]};
      w_diff  = {1'b0, w_shift} - {2'b00, r_b};
      if (r_op[2]) begin
         w_hi_nxt = w_diff[33] ? w_shift[31:0] : w_diff[31:0];
         w_lo_nxt = {r_lo[30:0], ~w_diff[33]};
      end else begin
         w_hi_nxt = w_sum[32:1];
         w_lo_nxt = {w_sum[0], r_lo[31:1]};
      end
   end

   // Sign fix-up and result selection, evaluated during FIX
   always_comb begin
      w_prod = r_neg ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
      w_quo  = r_neg ? (32'd0 - r_lo) : r_lo;
      w_rem  = r_neg ? (32'd0 - r_hi) : r_hi;
      if (r_op[2])
         w_fix = r_op[1] ? w_rem : w_quo;
      else
         w_fix = (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
   end

   // Control FSM, operand latch and iteration datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 6'd0;
         r_op     <= 3'd0;
         r_b      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_neg    <= 1'b0;
         r_result <= 32'd0;
      end else if (kill) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CALC;
                  r_cnt   <= 6'd0;
                  r_op    <= op;
                  r_neg   <= w_neg;
                  r_hi    <= 32'd0;
                  r_b     <= op[2] ? w_b_mag : w_a_mag;
                  r_lo    <= op[2] ? w_a_mag : w_b_mag;
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd31)
                  r_state <= S_FIX;
            end
            S_FIX: begin
               r_result <= w_fix;
               r_state  <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        kill;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          tests;
   int          failed;
   int          cyc;
   logic [31:0] q_res[$];
   int          q_cyc[$];
   logic [31:0] last_exp;
   logic [31:0] m_res;
   int          m_cyc;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse pops one expectation and checks value and timing
   always @(negedge clk) begin
      if (done) begin
         if (q_res.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
         end else begin
            m_res = q_res.pop_front();
            m_cyc = q_cyc.pop_front();
            tests++;
            if (result !== m_res) begin
               failed++;
               $display("FAIL result: got %08h, required %08h", result, m_res);
            end
            tests++;
            if (cyc != m_cyc) begin
               failed++;
               $display("FAIL latency: done at cycle %0d, required %0d", cyc, m_cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %08h, required %08h", name, got, exp);
      end
   endtask

   // Issue one operation; expected done is 33 edges after the accepting edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic rel_rst);
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      if (rel_rst) rst = 1'b0;
      @(posedge clk);
      #1;
      q_res.push_back(exp);
      q_cyc.push_back(cyc + 33);
      last_exp = exp;
      start = 1'b0;
      op = ~o; src_a = ~a; src_b = a ^ b;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 45; k++) begin
         @(negedge clk);
         if (q_res.size() == 0) break;
      end
      tests++;
      if (q_res.size() != 0) begin
         failed++;
         $display("FAIL timeout: %0d results outstanding, required 0", q_res.size());
         q_res.delete();
         q_cyc.delete();
      end
   endtask

   logic [2:0]  v_op [15];
   logic [31:0] v_a  [15];
   logic [31:0] v_b  [15];
   logic [31:0] v_e  [15];

   initial begin
      tests = 0; failed = 0; cyc = 0;
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
      last_exp = 32'd0;
      v_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
               3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
      v_a  = '{32'h7, 32'h7, 32'h7, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
               32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
      v_b  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7, 32'd2, 32'd2, 32'd7, 32'd7,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      v_e  = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h6, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
               32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};

      #2;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      // First op is accepted at the first edge after reset release
      issue(v_op[0], v_a[0], v_b[0], v_e[0], 1'b1);
      drain();
      for (int i = 1; i < 15; i++) begin
         issue(v_op[i], v_a[i], v_b[i], v_e[i], 1'b0);
         drain();
      end

      // Start while busy is ignored
      issue(3'd3, 32'h7, 32'hFFFFFFFD, 32'h6, 1'b0);
      repeat (9) @(negedge clk);
      op = 3'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // Kill at cycle 15 of a DIV
      issue(3'd4, 32'd100, 32'd7, 32'd14, 1'b0);
      q_res.delete();
      q_cyc.delete();
      repeat (14) @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_busy", {31'd0, busy}, 32'd0);
      check("kill_done", {31'd0, done}, 32'd0);
      check("kill_result", result, 32'h6);
      repeat (40) @(negedge clk);
      issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      drain();

      // Asynchronous reset mid-CALC
      issue(3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      q_res.delete();
      q_cyc.delete();
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have no parameters; datapath width is fixed at 32.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous, active-high.
REQ-004 start  input  1  Request; sampled only in IDLE.
REQ-005 kill  input  1  Synchronous abort of any in-flight operation.
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 src_a  input  32  Operand A, i.e. rs1 / dividend / multiplicand.
REQ-008 src_b  input  32  Operand B, i.e. rs2 / divisor / multiplier; same source as the ALU operand-B path.
REQ-009 busy  output  1  High while an operation is in progress.
REQ-010 done  output  1  One-cycle pulse when result is valid.
REQ-011 result  output  32  Registered result; holds its value until the next accepted start.

Function
REQ-012 The module SHALL use states IDLE, CALC, FIX and DONE.
- IDLE->CALC on start&!kill.
- CALC->FIX after 32 iterations.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-013 On acceptance the module SHALL latch op, src_a and src_b; later input changes SHALL NOT affect the operation.
REQ-014 Latency SHALL be fixed for every op: start sampled at edge t gives done=1 between edges t+33 and t+34.
REQ-015 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-016 done SHALL be 1 only in DONE.
REQ-017 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-018 kill in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse and result unchanged.
REQ-019 kill and start together in IDLE SHALL leave the module in IDLE.
REQ-020 Multiply SHALL be iterative shift-add, one bit per CALC cycle, over operand magnitudes, with a 64-bit product.
- Sign handling: MULH both signed, MULHSU A signed and B unsigned, MULHU and MUL unsigned.
- FIX SHALL negate the 64-bit product when the operand signs differ for the signed ops.
REQ-021 Multiply result selection SHALL be: MUL product[31:0]; MULH, MULHSU and MULHU product[63:32].
REQ-022 Divide SHALL be restoring, one quotient bit per CALC cycle, over magnitudes.
- FIX negates the quotient if the signs differ (DIV).
- FIX negates the remainder if the dividend is negative (REM).
REQ-023 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = src_a, for both signed and unsigned ops, with latency unchanged.
REQ-024 Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0x00000000, with latency unchanged.
REQ-025 The iteration counter SHALL be 6 bits, reset to 0 at each acceptance, with no wrap beyond 32 iterations.
REQ-026 result SHALL be written only on the FIX->DONE edge.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force:
- state IDLE
- busy=0, done=0
- result=0x00000000
- counter and internal operand/accumulator registers cleared.
REQ-028 Reset asserted mid-operation SHALL discard the operation, and no done pulse SHALL follow deassertion.
REQ-029 The first start SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-030 MUL 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006; done exactly 33 cycles after start.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
REQ-033 Second start pulsed at cycle 10 of a busy operation -> ignored; exactly one done; result from the first operands only.
REQ-034 kill at cycle 15 of a DIV -> IDLE next edge, no done, result retains its prior value; a new start is then accepted normally.
REQ-035 rst asserted asynchronously mid-CALC -> busy, done and result go to 0 before the next clk edge; no done pulse after release.
